// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by apb_master and by the apb_slave benches.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef logic [1:0] apb_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Counter width able to hold values up to n (n >= 1).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter; expired flags TIMEOUT_CYC-1 stalled cycles.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: valid/ready command port to APB SETUP/ACCESS, one-cycle response.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYC cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_t state;
  apb_state_t state_nx;
  logic       accept;
  logic       done;
  logic       abort;

  assign accept  = cmd_valid & cmd_ready;
  assign done    = (state == ST_ACCESS) & PREADY;
  assign PSEL    = (state != ST_IDLE);
  assign PENABLE = (state == ST_ACCESS);

`ifdef APB_TIMEOUT_EN
  logic expired;

  // Cleared during SETUP so every ACCESS phase starts counting from zero.
  apb_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (state == ST_SETUP),
    .inc    ((state == ST_ACCESS) && !PREADY),
    .expired(expired)
  );

  // PREADY on the same edge wins over the timeout.
  assign abort = (state == ST_ACCESS) & !PREADY & expired;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (done || abort) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Control: FSM and command handshake
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_ready <= (state_nx == ST_IDLE);
    end
  end

  // Request registers: held from accept until the next accept
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // Response: pulse for one cycle after completion or abort
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done | abort;
      rsp_err   <= abort;
      if (done) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (abort) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with a behavioural APB completer and reference memory.
module tb_apb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  typedef struct {
    int          acc;
    int          rsp;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          wait_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Completer: pops the planned wait count on entry to ACCESS, random noise elsewhere.
  int   remain = 0;
  bit   was_acc = 0;
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PRESET) begin
      if (!was_acc) remain = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      if (remain > 0) begin
        PREADY = 1'b0;
        PRDATA = $urandom;
        remain--;
      end else begin
        PREADY = 1'b1;
        if (PWRITE) begin
          slv_mem[PADDR] = PWDATA;
          PRDATA = $urandom;
        end else begin
          PRDATA = slv_mem.exists(PADDR) ? slv_mem[PADDR] : 32'h0;
        end
      end
      was_acc = 1;
    end else begin
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      was_acc = 0;
    end
  end

  // Monitor: bus protocol against the current transfer, responses against the scoreboard.
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESET) begin
      exp_q.delete();
    end else begin
      if (PSEL) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL psel_unexpected got=1 want=0 (cycle %0d)", cyc);
        end else begin
          chk("paddr", PADDR, exp_q[0].addr);
          chk("pwrite", 32'(PWRITE), 32'(exp_q[0].wr));
          if (exp_q[0].wr) chk("pwdata", PWDATA, exp_q[0].wdata);
          chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
          if (!PENABLE) chk("setup_cycle", 32'(cyc), 32'(exp_q[0].acc));
          else chk("access_window", 32'(cyc > exp_q[0].acc && cyc < exp_q[0].rsp), 32'd1);
        end
      end else begin
        chk("penable_idle", 32'(PENABLE), 32'd0);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected got=1 want=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.rsp));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  // Issue one command starting at a negedge; returns the accept edge number.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input bit tmo, output int acc);
    exp_t e;
    bit   ok = 0;
    acc       = -1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (cmd_ready) begin
        e.acc   = cyc + 1;
        e.wr    = w;
        e.addr  = a;
        e.wdata = d;
        e.err   = tmo;
        e.rsp   = tmo ? e.acc + 1 + TMO : e.acc + 2 + waits;
        e.rdata = (w || tmo) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
        if (w && !tmo) ref_mem[a] = d;
        acc = e.acc;
        wait_q.push_back(waits);
        exp_q.push_back(e);
        ok = 1;
      end
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=0 want=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(negedge PCLK);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int a1, a2, acc, g;
    bit seen;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (2) @(negedge PCLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Directed: write, read back, stalled read, back-to-back pair
    send(1'b1, 32'h0, 32'hDEADBEEF, 0, 1'b0, acc);
    drain();
    chk("slave_mem0", slv_mem.exists(32'h0) ? slv_mem[32'h0] : 32'h0, 32'hDEADBEEF);
    send(1'b0, 32'h0, 32'h0, 0, 1'b0, acc);
    drain();
    send(1'b0, 32'h0, 32'h0, 3, 1'b0, acc);
    drain();
    send(1'b1, 32'h4, 32'h12345678, 0, 1'b0, a1);
    send(1'b0, 32'h4, 32'h0, 0, 1'b0, a2);
    chk("b2b_spacing", 32'(a2 - a1), 32'd3);
    drain();

    // Randomised traffic with random gaps and wait states
    for (int i = 0; i < 150; i++) begin
      g = $urandom_range(0, 3);
      for (int k = 0; k < g - 1; k++) @(negedge PCLK);
      send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom,
           ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3), 1'b0, acc);
    end
    drain();

`ifdef APB_TIMEOUT_EN
    send(1'b0, 32'h8, 32'h0, 1000, 1'b1, acc);
    drain();
    chk("tmo_idle_psel", 32'(PSEL), 32'd0);
`endif

    // Reset in the middle of a stalled ACCESS phase
    send(1'b0, 32'h0, 32'h0, 6, 1'b0, acc);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (PENABLE) seen = 1;
      else @(negedge PCLK);
    end
    chk("reached_access", 32'(seen), 32'd1);
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("arst_psel", 32'(PSEL), 32'd0);
    chk("arst_penable", 32'(PENABLE), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rerst_ready", 32'(cmd_ready), 32'd1);
    send(1'b1, 32'h10, 32'hCAFEF00D, 0, 1'b0, acc);
    send(1'b0, 32'h10, 32'h0, 1, 1'b0, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
